// File: rtl/spi_flash_arb_pkg.sv
// ============================================================================
// Module      : spi_flash_arb_pkg
// Description : Shared state and owner encodings for the SPI flash pad-owner
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_flash_arb_pkg;

    typedef enum logic [1:0] {
        OWN_OT = 2'd0,
        OWN_YO = 2'd1,
        DRAIN  = 2'd2,
        GUARD  = 2'd3
    } spi_arb_state_e;

    localparam logic OwnerOt = 1'b0;
    localparam logic OwnerYo = 1'b1;

    // Steady state that corresponds to a given pad owner.
    function automatic spi_arb_state_e own_state(input logic owner);
        return owner ? OWN_YO : OWN_OT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_flash_obi_tracker.sv
// ============================================================================
// Module      : spi_flash_obi_tracker
// Description : Counts spimemio OBI transactions in flight, saturating at
//               MaxOutstanding and never wrapping below zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_obi_tracker #(
    parameter int MaxOutstanding = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 inc_i,
    input  logic                                 dec_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  count_o,
    output logic                                 full_o
);

    localparam int                c_CW  = $clog2(MaxOutstanding + 1);
    localparam logic [c_CW-1:0]   c_MAX = c_CW'(MaxOutstanding);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (inc_i && !dec_i && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (!inc_i && dec_i && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count_o = r_count;
    assign full_o  = (r_count == c_MAX);

    // A response with nothing outstanding indicates a protocol error upstream.
    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        dec_i |-> (r_count != '0));

endmodule

`default_nettype wire

// File: rtl/spi_flash_owner_arbiter.sv
// ============================================================================
// Module      : spi_flash_owner_arbiter
// Description : Hands the shared SPI flash pads between spimemio and the
//               OpenTitan SPI host once the old owner is drained and idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_owner_arbiter
    import spi_flash_arb_pkg::*;
#(
    parameter int unsigned GuardCycles    = 4,
    parameter int unsigned TimeoutCycles  = 1024,
    parameter int          MaxOutstanding = 2,
    parameter bit          ResetOwnerYo   = 1'b0,
    parameter int unsigned NumCS          = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             owner_req_i,
    input  logic             obi_req_i,
    input  logic             obi_gnt_i,
    input  logic             obi_rvalid_i,
    input  logic             ot_active_i,
    input  logic [NumCS-1:0] ot_csb_i,
    input  logic             yo_csb_i,
    output logic             use_spimemio_o,
    output logic             obi_block_o,
    output logic             switch_busy_o,
    output logic             switch_done_o,
    output logic             switch_err_o
);

    localparam int c_GW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;
    localparam int c_TW = $clog2(TimeoutCycles);
    localparam int c_CW = $clog2(MaxOutstanding + 1);

    localparam logic [c_GW-1:0]  c_GUARD_LOAD  = c_GW'(GuardCycles - 1);
    localparam logic [c_TW-1:0]  c_TO_LAST     = c_TW'(TimeoutCycles - 1);
    localparam spi_arb_state_e   c_RESET_STATE = ResetOwnerYo ? OWN_YO : OWN_OT;

    spi_arb_state_e    r_state;
    logic              owner_q;
    logic              target_q;
    logic              abort_lock_q;
    logic [c_GW-1:0]   r_guard_cnt;
    logic [c_TW-1:0]   r_to_cnt;

    logic [c_CW-1:0]   w_count;
    logic              w_full;
    logic              w_inc;
    logic              w_drain_ok;

    assign w_inc = obi_req_i & obi_gnt_i & ~obi_block_o;

    spi_flash_obi_tracker #(
        .MaxOutstanding (MaxOutstanding)
    ) u_tracker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_inc),
        .dec_i   (obi_rvalid_i),
        .count_o (w_count),
        .full_o  (w_full)
    );

    // The side being vacated decides what "idle" means.
    assign w_drain_ok = (owner_q == OwnerYo)
                      ? ((w_count == '0) && yo_csb_i)
                      : (!ot_active_i && (&ot_csb_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_RESET_STATE;
            owner_q       <= ResetOwnerYo;
            target_q      <= ResetOwnerYo;
            abort_lock_q  <= 1'b0;
            r_guard_cnt   <= '0;
            r_to_cnt      <= '0;
            switch_done_o <= 1'b0;
            switch_err_o  <= 1'b0;
        end else begin
            switch_done_o <= 1'b0;
            switch_err_o  <= 1'b0;
            if (owner_req_i == owner_q) begin
                abort_lock_q <= 1'b0;
            end

            case (r_state)
                OWN_OT, OWN_YO: begin
                    if ((owner_req_i != owner_q) && !abort_lock_q) begin
                        r_state  <= DRAIN;
                        target_q <= !owner_q;
                        r_to_cnt <= '0;
                    end
                end

                DRAIN: begin
                    if (r_to_cnt == c_TO_LAST) begin
                        r_state      <= own_state(owner_q);
                        switch_err_o <= 1'b1;
                        abort_lock_q <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (w_drain_ok) begin
                            r_state     <= GUARD;
                            r_guard_cnt <= c_GUARD_LOAD;
                        end
                    end
                end

                GUARD: begin
                    // A completed guard wins over a coincident timeout.
                    if (w_drain_ok && (r_guard_cnt == '0)) begin
                        owner_q       <= target_q;
                        switch_done_o <= 1'b1;
                        r_state       <= own_state(target_q);
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_state      <= own_state(owner_q);
                        switch_err_o <= 1'b1;
                        abort_lock_q <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (!w_drain_ok) begin
                            r_state <= DRAIN;
                        end else begin
                            r_guard_cnt <= r_guard_cnt - 1'b1;
                        end
                    end
                end

                default: r_state <= c_RESET_STATE;
            endcase
        end
    end

    assign use_spimemio_o = owner_q;
    assign switch_busy_o  = (r_state == DRAIN) || (r_state == GUARD);
    assign obi_block_o    = (r_state != OWN_YO) || w_full;

endmodule

`default_nettype wire
